// File: rtl/timer_nch.sv
// timer_nch: multi-channel programmable timer/counter with a shared irq.
// Each channel has its own prescaler, reload, compare and four output modes.
module timer_nch #(
    parameter int CH = 4,
    parameter int W  = 32,
    localparam int AW = $clog2(CH) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CH-1:0] ch_out,
    output logic          irq
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        M_ONE  = 2'b00,
        M_AUTO = 2'b01,
        M_PWM  = 2'b10,
        M_SQ   = 2'b11
    } mode_e;

    logic [CW-1:0] sel;

    logic [CH-1:0] en_q, en_d;
    logic [CH-1:0] irq_en_q, irq_en_d;
    logic [CH-1:0] pend_q, pend_d;
    logic [CH-1:0] out_q, out_d;
    logic [CH-1:0] sq_q, sq_d;

    mode_e        mode_q [CH];
    mode_e        mode_d [CH];
    logic [7:0]   pre_q  [CH];
    logic [7:0]   pre_d  [CH];
    logic [7:0]   psc_q  [CH];
    logic [7:0]   psc_d  [CH];
    logic [W-1:0] load_q [CH];
    logic [W-1:0] load_d [CH];
    logic [W-1:0] cmp_q  [CH];
    logic [W-1:0] cmp_d  [CH];
    logic [W-1:0] cnt_q  [CH];
    logic [W-1:0] cnt_d  [CH];

    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    generate
        if (CH > 1) begin : g_sel
            assign sel = addr[AW-1:2];
        end else begin : g_sel1
            assign sel = '0;
        end
    endgenerate

    // Per-channel next state: prescale, count, expire, then apply bus writes.
    always_comb begin
        logic tick, expire, hit, ctrl_wr, stop, start;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        pend_d   = pend_q;
        out_d    = out_q;
        sq_d     = sq_q;
        mode_d   = mode_q;
        pre_d    = pre_q;
        psc_d    = psc_q;
        load_d   = load_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        for (int c = 0; c < CH; c++) begin
            tick    = en_q[c] && (psc_q[c] == pre_q[c]);
            expire  = tick && (cnt_q[c] == '0);
            hit     = we && (sel == CW'(c));
            ctrl_wr = hit && (addr[1:0] == 2'd0);
            stop    = ctrl_wr && !wdata[0];
            start   = ctrl_wr && wdata[0] && !en_q[c];

            if (en_q[c]) begin
                psc_d[c] = tick ? 8'd0 : psc_q[c] + 8'd1;
            end

            if (tick) begin
                if (!expire) begin
                    cnt_d[c] = cnt_q[c] - W'(1);
                end else begin
                    pend_d[c] = 1'b1;
                    if (mode_q[c] == M_ONE) begin
                        en_d[c] = 1'b0;
                    end else if (!stop) begin
                        cnt_d[c] = load_q[c];
                    end
                    if (mode_q[c] == M_SQ) begin
                        sq_d[c] = ~sq_q[c];
                    end
                end
            end

            // A disabling CTRL write beats a same-cycle reload.
            if (ctrl_wr) begin
                mode_d[c]   = mode_e'(wdata[2:1]);
                irq_en_d[c] = wdata[3];
                pre_d[c]    = wdata[15:8];
                if (stop) begin
                    en_d[c] = 1'b0;
                end else if (start) begin
                    en_d[c]  = 1'b1;
                    cnt_d[c] = load_q[c];
                    psc_d[c] = 8'd0;
                end
            end
            if (hit && addr[1:0] == 2'd1) begin
                load_d[c] = wdata[W-1:0];
            end
            if (hit && addr[1:0] == 2'd2) begin
                cmp_d[c] = wdata[W-1:0];
            end
            // Clearing pending loses to a same-cycle expiry.
            if (hit && addr[1:0] == 2'd3 && !expire) begin
                pend_d[c] = 1'b0;
            end

            unique case (mode_d[c])
                M_ONE:  out_d[c] = en_d[c];
                M_AUTO: out_d[c] = expire && !stop;
                M_PWM:  out_d[c] = en_d[c] && (cnt_d[c] < cmp_d[c]);
                M_SQ:   out_d[c] = sq_d[c];
                default: out_d[c] = 1'b0;
            endcase
        end
    end

    // Register read mux; COUNT returns the pre-edge value.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            unique case (addr[1:0])
                2'd0: rdata_d = {pend_q[sel], 15'd0, pre_q[sel], 4'd0,
                                 irq_en_q[sel], mode_q[sel], en_q[sel]};
                2'd1: rdata_d = 32'(load_q[sel]);
                2'd2: rdata_d = 32'(cmp_q[sel]);
                2'd3: rdata_d = 32'(cnt_q[sel]);
                default: rdata_d = '0;
            endcase
        end
    end

    // Shared interrupt, one cycle behind pending.
    always_comb begin
        irq_d = |(pend_q & irq_en_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= '0;
            irq_en_q <= '0;
            pend_q   <= '0;
            out_q    <= '0;
            sq_q     <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                mode_q[c] <= M_ONE;
                pre_q[c]  <= '0;
                psc_q[c]  <= '0;
                load_q[c] <= '0;
                cmp_q[c]  <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            sq_q     <= sq_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            for (int c = 0; c < CH; c++) begin
                mode_q[c] <= mode_d[c];
                pre_q[c]  <= pre_d[c];
                psc_q[c]  <= psc_d[c];
                load_q[c] <= load_d[c];
                cmp_q[c]  <= cmp_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end

    assign rdata  = rdata_q;
    assign ch_out = out_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_timer_nch.sv
// tb_timer_nch: directed bench for timer_nch with a FIFO scoreboard.
// Two instances: default (CH=4, W=32) and a CH=8, W=16 variant.
module tb_timer_nch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, re = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  ch_out;
    logic        irq;

    logic        we2 = 1'b0, re2 = 1'b0;
    logic [4:0]  addr2 = '0;
    logic [31:0] wdata2 = '0;
    logic [31:0] rdata2;
    logic [7:0]  ch_out2;
    logic        irq2;

    int n_vec = 0;
    int n_err = 0;

    string       tq[$];
    logic [31:0] eq[$];

    timer_nch dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ch_out(ch_out), .irq(irq)
    );

    timer_nch #(.CH(8), .W(16)) dut2 (
        .clk(clk), .rst(rst), .we(we2), .re(re2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .ch_out(ch_out2), .irq(irq2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] e);
        tq.push_back(t);
        eq.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_vec++;
        if (eq.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed %h, no expected value", obs);
        end else begin
            t = tq.pop_front();
            e = eq.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string t, input logic [31:0] obs,
                       input logic [31:0] e);
        push(t, e);
        pop_cmp(obs);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input string t,
                      input logic [31:0] e);
        addr = a; re = 1'b1;
        push(t, e);
        step();
        re = 1'b0;
        pop_cmp(rdata);
    endtask

    task automatic wr2(input logic [4:0] a, input logic [31:0] d);
        addr2 = a; wdata2 = d; we2 = 1'b1;
        step();
        we2 = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a, input string t,
                       input logic [31:0] e);
        addr2 = a; re2 = 1'b1;
        push(t, e);
        step();
        re2 = 1'b0;
        pop_cmp(rdata2);
    endtask

    initial begin
        int ones;
        int n;

        // reset state
        step(); step();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_chout", {28'h0, ch_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        step();

        // auto-reload ch0: LOAD=3, pre=1
        wr(4'd1, 32'd3);
        wr(4'd0, 32'h0000_0103);
        for (int i = 1; i <= 16; i++) begin
            push("t1_count", 32'(3 - ((i - 1) % 8) / 2));
            push("t1_out", {31'h0, (i % 8 == 0)});
            addr = 4'd3; re = 1'b1;
            step();
            re = 1'b0;
            pop_cmp(rdata);
            pop_cmp({31'h0, ch_out[0]});
        end

        // one-shot ch1 with irq: LOAD=5, pre=0
        wr(4'd5, 32'd5);
        wr(4'd4, 32'h0000_0009);
        chk("t2_out_start", {31'h0, ch_out[1]}, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t2_out", {31'h0, ch_out[1]}, {31'h0, (i <= 5)});
            chk("t2_irq", {31'h0, irq}, {31'h0, (i >= 7)});
        end
        rd(4'd4, "t2_ctrl", 32'h8000_0008);
        wr(4'd7, 32'h0);
        chk("t2_irq_hold", {31'h0, irq}, 32'h1);
        step();
        chk("t2_irq_drop", {31'h0, irq}, 32'h0);

        // PWM ch2: LOAD=9, CMP=3
        wr(4'd9, 32'd9);
        wr(4'd10, 32'd3);
        wr(4'd8, 32'h0000_0005);
        chk("t3_out_start", {31'h0, ch_out[2]}, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("t3_pwm", {31'h0, ch_out[2]}, {31'h0, ((i % 10) >= 7)});
        end
        wr(4'd10, 32'd0);
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            if (ch_out[2]) ones++;
            step();
        end
        chk("t3_cmp0", 32'(ones), 32'd0);
        wr(4'd10, 32'd15);
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            if (ch_out[2]) ones++;
            step();
        end
        chk("t3_cmp15", 32'(ones), 32'd10);
        wr(4'd8, 32'h0);

        // square ch3: LOAD=1, pre=0, irq_en
        wr(4'd13, 32'd1);
        wr(4'd12, 32'h0000_000F);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t4_sq", {31'h0, ch_out[3]}, 32'((i / 2) % 2));
        end
        wr(4'd15, 32'h0);
        wr(4'd15, 32'h0);
        chk("t4_clr_ok", {31'h0, irq}, 32'h0);
        step();
        chk("t4_set_wins", {31'h0, irq}, 32'h1);
        rd(4'd12, "t4_ctrl", 32'h8000_000F);
        step();
        wr(4'd12, 32'h0000_000E);
        rd(4'd15, "t4_no_reload", 32'h0);
        rd(4'd12, "t4_ctrl_off", 32'h8000_000E);

        // sync reset mid-count
        chk("t5_irq_pre", {31'h0, irq}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rdata", rdata, 32'h0);
        chk("t5_chout", {28'h0, ch_out}, 32'h0);
        chk("t5_irq", {31'h0, irq}, 32'h0);
        rd(4'd3, "t5_cnt0", 32'h0);
        rd(4'd0, "t5_ctrl0", 32'h0);
        chk("t5_chout_idle", {28'h0, ch_out}, 32'h0);

        // CH=8, W=16: ch5 auto-reload LOAD=0xFFFF, pre=0
        wr2(5'd21, 32'h1234_FFFF);
        rd2(5'd21, "t6_load", 32'h0000_FFFF);
        wr2(5'd20, 32'h0000_0003);
        rd2(5'd23, "t6_count", 32'h0000_FFFF);
        n = 1;
        while (ch_out2[5] !== 1'b1 && n < 70000) begin
            step();
            n++;
        end
        chk("t6_period", 32'(n), 32'd65536);
        step();
        chk("t6_pulse_end", {31'h0, ch_out2[5]}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
